lsu_mem_stage: RTL and testbench
================================

LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: rising-edge clock.
REQ-003 Port reset, input, 1 bit: synchronous active-high reset.
REQ-004 Port execute_out_m, input, 32 bits: from EX_MEM; the effective address for memory ops, otherwise the result to pass through.
REQ-005 Port reg_readdata2_m, input, 32 bits: store data (rs2).
REQ-006 Port dmem_read_en_m and dmem_write_en_m, input, 1 bit each: load request and store request.
REQ-007 Port mem_size_m, input, 2 bits: access size; 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-008 Port mem_unsigned_m, input, 1 bit: 1 selects a zero-extended load (LBU/LHU).
REQ-009 Port reg_write_addr_m (input, 5 bits), reg_write_en_m (input, 1 bit) and reg_writedata_sel_m (input, 1 bit): writeback controls.
REQ-010 Ports dmem_readdata_m, execute_out_m_out, reg_write_addr_m_out, reg_write_en_m_out and reg_writedata_sel_m_out, outputs, widths as the inputs: to MEM_WB.
REQ-011 Port stall_m, output, 1 bit: freezes PC, FE_DE, DE_EX and EX_MEM while high.
REQ-012 Port misalign_err, output, 1 bit: pulse on a misaligned access.
REQ-013 Port bus_err, output, 1 bit: pulse on a memory timeout.
REQ-014 Bus ports: mem_req (out, 1), mem_we (out, 1), mem_addr (out, 32, bits [1:0] = 0), mem_be (out, 4), mem_wdata (out, 32), mem_rdata (in, 32), mem_ready (in, 1).

Function
REQ-015 A non-memory instruction (both enables low) SHALL pass through combinationally with stall_m=0 and mem_req=0.
REQ-016 The FSM SHALL have three states.
- IDLE: an aligned memory op present -> stall_m=1, go to REQ.
- REQ: mem_req=1 with address, data, we and be stable; stall_m=1; mem_ready=1 -> capture mem_rdata and go to DONE.
- DONE: stall_m=0; outputs valid; go to IDLE.
REQ-017 Latency SHALL be 2 + N stall cycles, where N is the number of REQ cycles before mem_ready; the minimum memory op therefore occupies 3 cycles.
REQ-018 mem_be SHALL be as follows.
- Byte: 1 shifted left by addr[1:0].
- Half: 0011 when addr[1]=0, 1100 when addr[1]=1.
- Word: 1111.
REQ-019 mem_wdata SHALL replicate the low byte (byte access) or the low half (half access) across all lanes.
REQ-020 Load data SHALL be shifted right by addr[1:0]*8 and then sign- or zero-extended to 32 bits per mem_unsigned_m.
REQ-021 Misaligned accesses are a half at an odd address and a word with addr[1:0] != 0.
REQ-022 On a misaligned access the block SHALL issue no request, pulse misalign_err for 1 cycle, force reg_write_en_m_out=0 and not stall.
REQ-023 If read and write enables are both high, the store SHALL take priority and the read SHALL be ignored.
REQ-024 A watchdog SHALL count REQ cycles; 256 cycles without mem_ready -> drop mem_req, pulse bus_err, force reg_write_en_m_out=0, go to DONE.
REQ-025 A store SHALL force reg_write_en_m_out=0.
REQ-026 dmem_readdata_m SHALL be the captured register value and SHALL hold until the next load completes.

Reset
REQ-027 reset SHALL set the state to IDLE and clear mem_req, stall_m, misalign_err, bus_err, the watchdog and the read-data register (all outputs 0).
REQ-028 Reset during REQ SHALL abandon the request: mem_req=0 in the cycle after reset is sampled, and a late mem_ready is ignored.

Structure
REQ-029 Package lsu_pkg SHALL hold mem_size_t, lsu_state_t (IDLE/REQ/DONE) and LSU_TIMEOUT=256.
REQ-030 A combinational sub-module lsu_align SHALL generate be/wdata, perform load extraction and extension, and detect misalignment.
REQ-031 The FSM, the watchdog and the data register SHALL reside in lsu_mem_stage.

Verification
REQ-032 LB at addr 0x103 with mem_rdata=0x80FF_1234 and mem_ready on the first REQ cycle -> mem_be=1000, dmem_readdata_m=0xFFFF_FF80, stall_m high 2 cycles.
REQ-033 SH of 0x0000_ABCD at addr 0x202 -> mem_addr=0x200, mem_be=1100, mem_wdata=0xABCD_ABCD, mem_we=1, reg_write_en_m_out=0.
REQ-034 LW at 0x105 -> misalign_err pulse, mem_req never asserted, stall_m=0.
REQ-035 LHU at 0x40 with mem_ready delayed 5 cycles and mem_rdata=0x1234_F00D -> stall 7 cycles, dmem_readdata_m=0x0000_F00D.
REQ-036 LW with mem_ready never asserted -> bus_err at REQ cycle 256, then IDLE.
REQ-037 Reset asserted in the 2nd REQ cycle -> mem_req=0 next cycle, state IDLE, all outputs 0.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the LSU memory stage
package lsu_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_RSVD = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    DONE = 2'b10
  } lsu_state_t;

  localparam int LSU_TIMEOUT = 256;
  localparam int WDOG_W      = $clog2(LSU_TIMEOUT);

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-enable/store-lane generation, load extraction and misalign detect
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_addr_lo,
  input  mem_size_t   i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_raw,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data,
  output logic        o_misalign
);

  logic [31:0] w_shifted;

  assign w_shifted = i_load_raw >> {i_addr_lo, 3'b000};

  always_comb begin
    o_be        = 4'b1111;
    o_wdata     = i_store_data;
    o_load_data = w_shifted;
    o_misalign  = 1'b0;
    case (i_size)
      MEM_BYTE: begin
        o_be        = 4'b0001 << i_addr_lo;
        o_wdata     = {4{i_store_data[7:0]}};
        o_load_data = {{24{w_shifted[7] & ~i_unsigned}}, w_shifted[7:0]};
      end
      MEM_HALF: begin
        o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata     = {2{i_store_data[15:0]}};
        o_load_data = {{16{w_shifted[15] & ~i_unsigned}}, w_shifted[15:0]};
        o_misalign  = i_addr_lo[0];
      end
      // word and the reserved encoding behave identically
      default: o_misalign = |i_addr_lo;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - MEM pipeline stage: bus handshake FSM, watchdog and load-data register
module lsu_mem_stage
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] execute_out_m,
  input  logic [31:0] reg_readdata2_m,
  input  logic        dmem_read_en_m,
  input  logic        dmem_write_en_m,
  input  logic [1:0]  mem_size_m,
  input  logic        mem_unsigned_m,
  input  logic [4:0]  reg_write_addr_m,
  input  logic        reg_write_en_m,
  input  logic        reg_writedata_sel_m,
  output logic [31:0] dmem_readdata_m,
  output logic [31:0] execute_out_m_out,
  output logic [4:0]  reg_write_addr_m_out,
  output logic        reg_write_en_m_out,
  output logic        reg_writedata_sel_m_out,
  output logic        stall_m,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready
);

  lsu_state_t        r_state;
  lsu_state_t        w_next_state;
  logic [WDOG_W-1:0] r_wdog;
  logic [31:0]       r_rdata;
  logic              r_timeout;

  logic              w_mem_op;
  logic              w_is_store;
  logic              w_is_load;
  logic              w_misalign;
  logic              w_timeout_hit;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_load_data;

  // a store wins when both enables are set
  assign w_is_store    = dmem_write_en_m;
  assign w_is_load     = dmem_read_en_m & ~dmem_write_en_m;
  assign w_mem_op      = dmem_read_en_m | dmem_write_en_m;
  assign w_timeout_hit = (r_state == REQ) && !mem_ready &&
                         (r_wdog == WDOG_W'(LSU_TIMEOUT - 1));

  lsu_align u_align (
    .i_addr_lo    (execute_out_m[1:0]),
    .i_size       (mem_size_t'(mem_size_m)),
    .i_unsigned   (mem_unsigned_m),
    .i_store_data (reg_readdata2_m),
    .i_load_raw   (mem_rdata),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data),
    .o_misalign   (w_misalign)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_wdog    <= '0;
      r_rdata   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_wdog    <= (r_state == REQ) ? r_wdog + WDOG_W'(1) : '0;
      r_timeout <= w_timeout_hit;
      if ((r_state == REQ) && mem_ready && w_is_load) begin
        r_rdata <= w_load_data;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    stall_m      = 1'b0;
    mem_req      = 1'b0;
    misalign_err = 1'b0;
    bus_err      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_mem_op) begin
          if (w_misalign) begin
            misalign_err = 1'b1;
          end else begin
            stall_m      = 1'b1;
            w_next_state = REQ;
          end
        end
      end
      REQ: begin
        stall_m = 1'b1;
        mem_req = 1'b1;
        if (mem_ready) begin
          w_next_state = DONE;
        end else if (w_timeout_hit) begin
          bus_err      = 1'b1;
          w_next_state = DONE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  assign mem_we    = mem_req & w_is_store;
  assign mem_addr  = mem_req ? {execute_out_m[31:2], 2'b00} : '0;
  assign mem_be    = mem_req ? w_be : '0;
  assign mem_wdata = mem_req ? w_wdata : '0;

  assign dmem_readdata_m         = r_rdata;
  assign execute_out_m_out       = execute_out_m;
  assign reg_write_addr_m_out    = reg_write_addr_m;
  assign reg_writedata_sel_m_out = reg_writedata_sel_m;
  // MEM_WB keeps running during a stall, so the write is held back until the data is final
  assign reg_write_en_m_out = reg_write_en_m & ~stall_m & ~w_is_store & ~misalign_err &
                              ~((r_state == DONE) & r_timeout);

endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb/tb_lsu_mem_stage.sv - self-checking bench for lsu_mem_stage
module tb_lsu_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] execute_out_m, reg_readdata2_m, mem_rdata;
  logic        dmem_read_en_m, dmem_write_en_m, mem_unsigned_m, mem_ready;
  logic [1:0]  mem_size_m;
  logic [4:0]  reg_write_addr_m;
  logic        reg_write_en_m, reg_writedata_sel_m;
  logic [31:0] dmem_readdata_m, execute_out_m_out, mem_addr, mem_wdata;
  logic [4:0]  reg_write_addr_m_out;
  logic        reg_write_en_m_out, reg_writedata_sel_m_out;
  logic        stall_m, misalign_err, bus_err, mem_req, mem_we;
  logic [3:0]  mem_be;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_rd = 32'h0;

  always #5 clk = ~clk;

  lsu_mem_stage dut (
    .clk(clk), .reset(reset),
    .execute_out_m(execute_out_m), .reg_readdata2_m(reg_readdata2_m),
    .dmem_read_en_m(dmem_read_en_m), .dmem_write_en_m(dmem_write_en_m),
    .mem_size_m(mem_size_m), .mem_unsigned_m(mem_unsigned_m),
    .reg_write_addr_m(reg_write_addr_m), .reg_write_en_m(reg_write_en_m),
    .reg_writedata_sel_m(reg_writedata_sel_m),
    .dmem_readdata_m(dmem_readdata_m), .execute_out_m_out(execute_out_m_out),
    .reg_write_addr_m_out(reg_write_addr_m_out), .reg_write_en_m_out(reg_write_en_m_out),
    .reg_writedata_sel_m_out(reg_writedata_sel_m_out),
    .stall_m(stall_m), .misalign_err(misalign_err), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic        rd, wr, uns, rwe;
    logic [1:0]  size;
    int          delay;  // REQ cycles before mem_ready; negative means never
  } op_t;

  typedef struct {
    int          stall_cnt;
    bit          req_seen, mis_seen, bus_seen, done;
    int          bus_idx;
    logic [3:0]  be;
    logic [31:0] maddr, mwdata, rd_out, exo;
    logic        we, rwe_out;
  } obs_t;

  typedef struct {
    op_t         op;
    logic [3:0]  be;
    logic [31:0] wd, ld;
    int          stall;
    bit          mis, rwe;
  } vec_t;

  function automatic op_t mk_op(logic [31:0] addr, logic [31:0] wdata, logic rd, logic wr,
                                logic [1:0] size, logic uns, logic [31:0] rdata, int delay);
    op_t o;
    o.addr = addr; o.wdata = wdata; o.rd = rd; o.wr = wr; o.size = size;
    o.uns = uns; o.rdata = rdata; o.delay = delay; o.rwe = 1'b1;
    return o;
  endfunction

  function automatic vec_t mkv(op_t o, logic [3:0] be, logic [31:0] wd, logic [31:0] ld,
                               int stall, bit mis, bit rwe);
    vec_t v;
    v.op = o; v.be = be; v.wd = wd; v.ld = ld; v.stall = stall; v.mis = mis; v.rwe = rwe;
    return v;
  endfunction

  // Reference: lanes, replication and extension computed arithmetically from the access rules
  function automatic void model(input op_t o, output logic [3:0] be, output logic [31:0] wd,
                                output logic [31:0] ld, output bit mis);
    int n, off;
    longint unsigned raw, span;
    n = (o.size == 2'd0) ? 1 : (o.size == 2'd1) ? 2 : 4;
    off = int'(o.addr % 4);
    mis = (off % n) != 0;
    be = '0;
    wd = '0;
    for (int k = 0; k < 4; k++) begin
      be[k] = (k >= off) && (k < off + n);
      wd[k*8 +: 8] = 8'(o.wdata >> (8 * (k % n)));
    end
    span = 64'd1 << (8 * n);
    raw = longint'(o.rdata) >> (8 * off);
    raw = raw % span;
    if (!o.uns && raw >= (span >> 1)) raw = raw - span;
    ld = raw[31:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic zero_inputs();
    execute_out_m = '0; reg_readdata2_m = '0; dmem_read_en_m = 0; dmem_write_en_m = 0;
    mem_size_m = '0; mem_unsigned_m = 0; reg_write_addr_m = '0; reg_write_en_m = 0;
    reg_writedata_sel_m = 0; mem_rdata = '0; mem_ready = 0;
  endtask

  // Drive one instruction and act as the memory until the stage stops stalling
  task automatic run_op(input op_t o, output obs_t r);
    int reqcnt;
    r.stall_cnt = 0; r.req_seen = 0; r.mis_seen = 0; r.bus_seen = 0; r.done = 0;
    r.bus_idx = 0; r.be = '0; r.maddr = '0; r.mwdata = '0; r.rd_out = '0; r.exo = '0;
    r.we = 0; r.rwe_out = 0;
    reqcnt = 0;
    @(negedge clk);
    execute_out_m = o.addr; reg_readdata2_m = o.wdata; dmem_read_en_m = o.rd;
    dmem_write_en_m = o.wr; mem_size_m = o.size; mem_unsigned_m = o.uns;
    reg_write_addr_m = 5'd7; reg_write_en_m = o.rwe; reg_writedata_sel_m = 1'b1;
    mem_rdata = o.rdata;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc > 0) @(negedge clk);
      mem_ready = mem_req && (o.delay >= 0) && (reqcnt == o.delay);
      if (mem_req) begin
        r.req_seen = 1; r.be = mem_be; r.maddr = mem_addr; r.mwdata = mem_wdata; r.we = mem_we;
        reqcnt++;
      end
      #1;
      if (misalign_err) r.mis_seen = 1;
      if (bus_err && !r.bus_seen) begin r.bus_seen = 1; r.bus_idx = reqcnt; end
      if (stall_m) r.stall_cnt++;
      else begin
        r.rd_out = dmem_readdata_m; r.rwe_out = reg_write_en_m_out; r.exo = execute_out_m_out;
        r.done = 1;
        break;
      end
    end
    mem_ready = 0;
  endtask

  task automatic compare_op(input string nm, input op_t o, input obs_t r, input logic [3:0] e_be,
                            input logic [31:0] e_wd, input logic [31:0] e_ld, input int e_stall,
                            input bit e_mis, input bit e_rwe);
    bit e_req;
    e_req = (o.rd | o.wr) && !e_mis;
    chk({nm, " finished"}, 32'(r.done), 32'd1);
    chk({nm, " stall_cycles"}, 32'(r.stall_cnt), 32'(e_stall));
    chk({nm, " misalign_err"}, 32'(r.mis_seen), 32'(e_mis));
    chk({nm, " mem_req"}, 32'(r.req_seen), 32'(e_req));
    chk({nm, " bus_err"}, 32'(r.bus_seen), 32'd0);
    if (e_req) begin
      chk({nm, " mem_be"}, 32'(r.be), 32'(e_be));
      chk({nm, " mem_addr"}, r.maddr, o.addr & ~32'h3);
      chk({nm, " mem_we"}, 32'(r.we), 32'(o.wr));
      chk({nm, " mem_wdata"}, r.mwdata, e_wd);
    end
    chk({nm, " dmem_readdata"}, r.rd_out, e_ld);
    chk({nm, " reg_write_en"}, 32'(r.rwe_out), 32'(e_rwe));
    chk({nm, " execute_pass"}, r.exo, o.addr);
  endtask

  vec_t vecs[10];
  op_t  o;
  obs_t r;
  logic [3:0]  m_be;
  logic [31:0] m_wd, m_ld;
  bit          m_mis, memop, e_mis;

  initial begin
    vecs[0] = mkv(mk_op(32'h103, 32'h0, 1, 0, 2'b00, 0, 32'h80FF_1234, 0), 4'b1000, 32'h0, 32'hFFFF_FF80, 2, 0, 1);
    vecs[1] = mkv(mk_op(32'h202, 32'h0000_ABCD, 0, 1, 2'b01, 0, 32'h0, 0), 4'b1100, 32'hABCD_ABCD, 32'hFFFF_FF80, 2, 0, 0);
    vecs[2] = mkv(mk_op(32'h105, 32'h0, 1, 0, 2'b10, 0, 32'h5555_5555, 0), 4'b0000, 32'h0, 32'hFFFF_FF80, 0, 1, 0);
    vecs[3] = mkv(mk_op(32'h40, 32'h0, 1, 0, 2'b01, 1, 32'h1234_F00D, 5), 4'b0011, 32'h0, 32'h0000_F00D, 7, 0, 1);
    vecs[4] = mkv(mk_op(32'h42, 32'h0, 1, 0, 2'b01, 0, 32'h8001_0000, 1), 4'b1100, 32'h0, 32'hFFFF_8001, 3, 0, 1);
    vecs[5] = mkv(mk_op(32'h001, 32'h1234_56A5, 0, 1, 2'b00, 0, 32'h0, 2), 4'b0010, 32'hA5A5_A5A5, 32'hFFFF_8001, 4, 0, 0);
    vecs[6] = mkv(mk_op(32'h10, 32'hDEAD_BEEF, 1, 1, 2'b11, 0, 32'h1111_1111, 0), 4'b1111, 32'hDEAD_BEEF, 32'hFFFF_8001, 2, 0, 0);
    vecs[7] = mkv(mk_op(32'h203, 32'h0, 0, 1, 2'b01, 0, 32'h0, 0), 4'b0000, 32'h0, 32'hFFFF_8001, 0, 1, 0);
    vecs[8] = mkv(mk_op(32'h1234_5677, 32'h0, 0, 0, 2'b10, 0, 32'h0, 0), 4'b0000, 32'h0, 32'hFFFF_8001, 0, 0, 1);
    vecs[9] = mkv(mk_op(32'h102, 32'h0, 1, 0, 2'b00, 1, 32'h80FF_1234, 0), 4'b0100, 32'h0, 32'h0000_00FF, 2, 0, 1);

    zero_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset stall_m", 32'(stall_m), 32'd0);
    chk("reset misalign_err", 32'(misalign_err), 32'd0);
    chk("reset bus_err", 32'(bus_err), 32'd0);
    chk("reset dmem_readdata", dmem_readdata_m, 32'd0);
    chk("reset reg_write_en", 32'(reg_write_en_m_out), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, r);
      compare_op($sformatf("vec%0d", i), vecs[i].op, r, vecs[i].be, vecs[i].wd, vecs[i].ld,
                 vecs[i].stall, vecs[i].mis, vecs[i].rwe);
      exp_rd = vecs[i].ld;
    end

    o = mk_op(32'h80, 32'h0, 1, 0, 2'b10, 0, 32'h7777_7777, -1);
    run_op(o, r);
    chk("timeout bus_err seen", 32'(r.bus_seen), 32'd1);
    chk("timeout bus_err req_cycle", 32'(r.bus_idx), 32'd256);
    chk("timeout stall_cycles", 32'(r.stall_cnt), 32'd257);
    chk("timeout reg_write_en", 32'(r.rwe_out), 32'd0);
    chk("timeout dmem_readdata", r.rd_out, exp_rd);
    o = mk_op(32'h84, 32'h0, 0, 0, 2'b10, 0, 32'h0, 0);
    run_op(o, r);
    compare_op("after_timeout", o, r, 4'b0, 32'h0, exp_rd, 0, 0, 1);

    for (int i = 0; i < 40; i++) begin
      o = mk_op($urandom(), $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom(),
                int'($urandom_range(0, 6)));
      o.rwe = 1'($urandom_range(0, 1));
      model(o, m_be, m_wd, m_ld, m_mis);
      memop = o.rd | o.wr;
      e_mis = memop && m_mis;
      if (memop && !m_mis && o.rd && !o.wr) exp_rd = m_ld;
      run_op(o, r);
      compare_op($sformatf("rand%0d", i), o, r, m_be, m_wd, exp_rd,
                 (memop && !m_mis) ? 2 + o.delay : 0, e_mis, o.rwe && !o.wr && !e_mis);
    end

    @(negedge clk);
    execute_out_m = 32'h300; dmem_read_en_m = 1; dmem_write_en_m = 0; mem_size_m = 2'b10;
    reg_write_en_m = 1; mem_rdata = 32'hCAFE_F00D; mem_ready = 0;
    #1 chk("rst_seq idle stall", 32'(stall_m), 32'd1);
    @(negedge clk); #1 chk("rst_seq req1 mem_req", 32'(mem_req), 32'd1);
    @(negedge clk); reset = 1'b1;
    #1 chk("rst_seq req2 mem_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    zero_inputs();
    mem_ready = 1'b1;
    #1;
    chk("rst_seq mem_req", 32'(mem_req), 32'd0);
    chk("rst_seq stall_m", 32'(stall_m), 32'd0);
    chk("rst_seq bus_err", 32'(bus_err), 32'd0);
    chk("rst_seq misalign_err", 32'(misalign_err), 32'd0);
    chk("rst_seq mem_be", 32'(mem_be), 32'd0);
    chk("rst_seq dmem_readdata", dmem_readdata_m, 32'd0);
    chk("rst_seq reg_write_en", 32'(reg_write_en_m_out), 32'd0);
    @(negedge clk); #1;
    chk("rst_seq late_ready mem_req", 32'(mem_req), 32'd0);
    chk("rst_seq late_ready dmem_readdata", dmem_readdata_m, 32'd0);
    mem_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
